div_sequencer: RTL and testbench

//   Control stage directly upstream of the shift-subtract divider stage.
//   - Accepts dividend/divisor over a valid/ready handshake.
//   - Drives the stage's start/D controls for exactly DW iterations.
//   - Captures the quotient and remainder from the stage's working register.
//   - Returns the result over a valid/ready handshake; divide-by-zero is handled locally.

---
 rtl/div_sequencer.sv | 163 ++++++++++++++++
 tb/tb_div_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - control sequencer for a shift-subtract divider stage
// Optional result self-check is enabled by defining DIVSEQ_CHECK_EN.
module div_sequencer #(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero,
  output logic [2*DW:0]   dp_inX,
  output logic [DW-1:0]   dp_Div,
  output logic            dp_start,
  output logic            dp_D,
  input  logic [2*DW:0]   dp_outX
`ifdef DIVSEQ_CHECK_EN
  ,
  output logic            chk_err
`endif
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dividend_q, dividend_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic [DW-1:0]   quotient_q, quotient_d;
  logic [DW-1:0]   remainder_q, remainder_d;
  logic            div_zero_q, div_zero_d;
  logic            out_valid_q, out_valid_d;
  logic            dp_start_q, dp_start_d;
  logic            dp_D_q, dp_D_d;
  logic            outx_msb_unused;
`ifdef DIVSEQ_CHECK_EN
  logic            chk_err_q, chk_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    dp_start_d  = dp_start_q;
    dp_D_d      = dp_D_q;
`ifdef DIVSEQ_CHECK_EN
    chk_err_d   = chk_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          cnt_d      = '0;
          // Divide-by-zero never touches the stage; answer is produced here.
          if (divisor == '0) begin
            state_d     = OUT;
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d    = RUN;
            dp_start_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
          dp_D_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        quotient_d  = dp_outX[DW-1:0];
        remainder_d = dp_outX[2*DW-1:DW];
        div_zero_d  = 1'b0;
        out_valid_d = 1'b1;
        dp_start_d  = 1'b0;
        dp_D_d      = 1'b0;
        state_d     = OUT;
`ifdef DIVSEQ_CHECK_EN
        chk_err_d = (dp_outX[DW-1:0] != (dividend_q / divisor_q)) ||
                    (dp_outX[2*DW-1:DW] != (dividend_q % divisor_q));
`endif
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
`ifdef DIVSEQ_CHECK_EN
          chk_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dp_start_q  <= 1'b0;
      dp_D_q      <= 1'b0;
`ifdef DIVSEQ_CHECK_EN
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      dp_start_q  <= dp_start_d;
      dp_D_q      <= dp_D_d;
`ifdef DIVSEQ_CHECK_EN
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  // in_ready is a state decode so it is high on the first IDLE cycle after reset.
  assign in_ready        = (state_q == IDLE) && !rst;
  assign out_valid       = out_valid_q;
  assign quotient        = quotient_q;
  assign remainder       = remainder_q;
  assign div_zero        = div_zero_q;
  assign dp_inX          = {{(DW+1){1'b0}}, dividend_q};
  assign dp_Div          = divisor_q;
  assign dp_start        = dp_start_q;
  assign dp_D            = dp_D_q;
  assign outx_msb_unused = dp_outX[2*DW];
`ifdef DIVSEQ_CHECK_EN
  assign chk_err         = chk_err_q;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer with a shift-subtract stage model
// Define DIVSEQ_CHECK_EN to also exercise chk_err.
module tb_div_sequencer;

  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_zero;
  logic [2*DW:0]   dp_inX;
  logic [DW-1:0]   dp_Div;
  logic            dp_start;
  logic            dp_D;
  logic [2*DW:0]   dp_outX;
`ifdef DIVSEQ_CHECK_EN
  logic            chk_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_sequencer #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero),
    .dp_inX(dp_inX), .dp_Div(dp_Div), .dp_start(dp_start), .dp_D(dp_D),
    .dp_outX(dp_outX)
`ifdef DIVSEQ_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Restoring shift-subtract stage: start=0 arms a load, first enabled edge
  // loads inX and iterates, D clears the register.
  logic [2*DW:0] stage_x = '0;
  logic          stage_armed = 1'b1;

  function automatic logic [2*DW:0] stage_step(input logic [2*DW:0] x, input logic [DW-1:0] d);
    logic [2*DW:0] s;
    logic [DW:0]   up;
    s  = x << 1;
    up = s[2*DW:DW];
    if (up >= {1'b0, d}) begin
      s[2*DW:DW] = up - {1'b0, d};
      s[0]       = 1'b1;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (!dp_start) begin
      stage_armed <= 1'b1;
    end else if (dp_D) begin
      stage_x     <= '0;
      stage_armed <= 1'b1;
    end else begin
      stage_x     <= stage_step(stage_armed ? dp_inX : stage_x, dp_Div);
      stage_armed <= 1'b0;
    end
  end
  assign dp_outX = stage_x;

  // Transaction-level model: one divide in flight, tracked by edges since accept.
  bit  m_live = 0, m_busy = 0;
  int  m_lat = 0, m_a = 0, m_b = 0;
  bit  p_rst = 0, p_fire = 0, p_take = 0;
  int  p_a = 0, p_b = 0;

  always @(negedge clk) begin
    bit ev, st;
    if (p_rst) begin
      m_busy = 0;
      m_live = 1;
    end else if (p_fire) begin
      m_busy = 1; m_lat = 1; m_a = p_a; m_b = p_b;
    end else if (p_take) begin
      m_busy = 0;
    end else if (m_busy) begin
      m_lat++;
    end
    ev = m_busy && ((m_b == 0) || (m_lat >= DW + 2));
    st = m_busy && (m_b != 0) && (m_lat <= DW + 1);
    if (m_live) begin
      check("mon_in_ready", 32'(in_ready), 32'(!m_busy && !rst));
      check("mon_out_valid", 32'(out_valid), 32'(ev));
      check("mon_dp_start", 32'(dp_start), 32'(st));
      check("mon_dp_D", 32'(dp_D), 32'(st && (m_lat == DW + 1)));
      if (ev) begin
        check("mon_quotient", 32'(quotient), (m_b == 0) ? (1 << DW) - 1 : m_a / m_b);
        check("mon_remainder", 32'(remainder), (m_b == 0) ? m_a : m_a % m_b);
        check("mon_div_zero", 32'(div_zero), 32'(m_b == 0));
      end
      if (st) begin
        check("mon_dp_inX", 32'(dp_inX), m_a);
        check("mon_dp_Div", 32'(dp_Div), m_b);
      end
      if (p_rst) begin
        check("mon_rst_quotient", 32'(quotient), 0);
        check("mon_rst_remainder", 32'(remainder), 0);
        check("mon_rst_div_zero", 32'(div_zero), 0);
      end
`ifdef DIVSEQ_CHECK_EN
      check("mon_chk_err", 32'(chk_err), 0);
`endif
    end
    p_rst  = rst;
    p_fire = m_live && !rst && !m_busy && in_valid;
    p_take = m_live && !rst && ev && out_ready;
    p_a    = int'(dividend);
    p_b    = int'(divisor);
  end

  task automatic wait_valid(output int edges, output bit seen_start);
    edges = 0;
    seen_start = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen_start |= dp_start;
      if (out_valid) return;
      @(posedge clk); #1;
      edges++;
    end
    check("out_valid_timeout", 0, 1);
  endtask

  task automatic run_div(input int a, input int b, input int hold,
                         input int eq, input int er, input int ez, input int elat);
    int edges;
    bit seen_start, got;
    @(posedge clk); #1;
    dividend = DW'(a); divisor = DW'(b); in_valid = 1'b1; out_ready = (hold == 0);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("accept_timeout", 32'(got), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(edges, seen_start);
    check("latency", edges + 1, elat);
    check("quotient", 32'(quotient), eq);
    check("remainder", 32'(remainder), er);
    check("div_zero", 32'(div_zero), ez);
    if (ez != 0) check("zero_no_start", 32'(seen_start), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_quotient", 32'(quotient), eq);
      check("hold_remainder", 32'(remainder), er);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int edges;
    bit ss;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dp_start", 32'(dp_start), 0);
    check("rst_quotient", 32'(quotient), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div(13, 3, 0, 4, 1, 0, 6);
    run_div(15, 1, 0, 15, 0, 0, 6);
    run_div(2, 9, 0, 0, 2, 0, 6);
    run_div(7, 0, 0, 15, 7, 1, 1);
    run_div(13, 3, 5, 4, 1, 0, 6);
    run_div(0, 5, 0, 0, 0, 0, 6);
    run_div(15, 15, 0, 1, 0, 0, 6);

    // Reset pulsed during the second RUN cycle discards the divide.
    @(posedge clk); #1;
    dividend = 4'd15; divisor = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("rr_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rr_dp_start", 32'(dp_start), 0);
    check("rr_out_valid", 32'(out_valid), 0);
    check("rr_in_ready_after", 32'(in_ready), 1);
    run_div(9, 4, 0, 2, 1, 0, 6);

    // Back-to-back with in_valid held high.
    @(posedge clk); #1;
    dividend = 4'd6; divisor = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
    wait_valid(edges, ss);
    check("b2b1_quotient", 32'(quotient), 3);
    check("b2b1_remainder", 32'(remainder), 0);
    check("b2b1_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    dividend = 4'd14; divisor = 4'd5;
    wait_valid(edges, ss);
    check("b2b2_latency", edges + 1, 7);
    check("b2b2_quotient", 32'(quotient), 2);
    check("b2b2_remainder", 32'(remainder), 4);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
